// File: rtl/execute_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline.
// Operand forwarding, ALU, condition evaluation, flag update and branch
// resolution, plus the Execute->Memory pipeline register.
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic             ALUSrcE,
  input  logic [1:0]       ALUControlE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       FlagsE,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic [3:0]       WA3E,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [3:0]       FlagsOut,
  output logic             BranchTakenE,
  output logic [WIDTH-1:0] BranchTargetE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM
);

  logic [WIDTH-1:0] src_a_s;
  logic [WIDTH-1:0] fwd_b_s;
  logic [WIDTH-1:0] src_b_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             is_sub_s;
  logic             n_s, z_s, c_s, v_s;
  logic             cond_ex_s;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [3:0]       wa3_q, wa3_d;
  logic             pcsrc_q, pcsrc_d;
  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             memwrite_q, memwrite_d;

  // Forwarding muxes: select 11 falls back to the register file operand.
  always_comb begin
    src_a_s = RD1E;
    fwd_b_s = RD2E;
    case (ForwardAE)
      2'b01:   src_a_s = ResultW;
      2'b10:   src_a_s = alu_out_q;
      default: src_a_s = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b_s = ResultW;
      2'b10:   fwd_b_s = alu_out_q;
      default: fwd_b_s = RD2E;
    endcase
    if (ALUSrcE) begin
      src_b_s = ExtImmE;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // ALU: subtraction is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    is_sub_s  = (ALUControlE == 2'b01);
    b_eff_s   = is_sub_s ? ~src_b_s : src_b_s;
    sum_s     = {1'b0, src_a_s} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
    alu_res_s = sum_s[WIDTH-1:0];
    c_s       = 1'b0;
    v_s       = 1'b0;
    case (ALUControlE)
      2'b00, 2'b01: begin
        alu_res_s = sum_s[WIDTH-1:0];
        c_s       = sum_s[WIDTH];
        v_s       = (src_a_s[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != src_a_s[WIDTH-1]);
      end
      2'b10:   alu_res_s = src_a_s & src_b_s;
      2'b11:   alu_res_s = src_a_s | src_b_s;
      default: alu_res_s = sum_s[WIDTH-1:0];
    endcase
    n_s = alu_res_s[WIDTH-1];
    z_s = (alu_res_s == {WIDTH{1'b0}});
  end

  // Condition check against the incoming flags {N,Z,C,V}.
  always_comb begin
    case (CondE)
      4'h0:    cond_ex_s = FlagsE[2];
      4'h1:    cond_ex_s = ~FlagsE[2];
      4'h2:    cond_ex_s = FlagsE[1];
      4'h3:    cond_ex_s = ~FlagsE[1];
      4'h4:    cond_ex_s = FlagsE[3];
      4'h5:    cond_ex_s = ~FlagsE[3];
      4'h6:    cond_ex_s = FlagsE[0];
      4'h7:    cond_ex_s = ~FlagsE[0];
      4'h8:    cond_ex_s = FlagsE[1] & ~FlagsE[2];
      4'h9:    cond_ex_s = ~FlagsE[1] | FlagsE[2];
      4'hA:    cond_ex_s = (FlagsE[3] == FlagsE[0]);
      4'hB:    cond_ex_s = (FlagsE[3] != FlagsE[0]);
      4'hC:    cond_ex_s = ~FlagsE[2] & (FlagsE[3] == FlagsE[0]);
      4'hD:    cond_ex_s = FlagsE[2] | (FlagsE[3] != FlagsE[0]);
      default: cond_ex_s = 1'b1;
    endcase
  end

  // Flag update, branch resolution and next-state for the Memory register.
  always_comb begin
    if (FlagWriteE[1] && cond_ex_s) begin
      FlagsOut[3:2] = {n_s, z_s};
    end else begin
      FlagsOut[3:2] = FlagsE[3:2];
    end
    if (FlagWriteE[0] && cond_ex_s) begin
      FlagsOut[1:0] = {c_s, v_s};
    end else begin
      FlagsOut[1:0] = FlagsE[1:0];
    end
    BranchTakenE  = BranchE & cond_ex_s;
    BranchTargetE = alu_res_s;
    alu_out_d     = alu_res_s;
    write_data_d  = fwd_b_s;
    wa3_d         = WA3E;
    pcsrc_d       = PCSrcE & cond_ex_s;
    regwrite_d    = RegWriteE & cond_ex_s;
    memwrite_d    = MemWriteE & cond_ex_s;
    memtoreg_d    = MemtoRegE;
  end

  // Execute->Memory pipeline register; advances every cycle, async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q    <= {WIDTH{1'b0}};
      write_data_q <= {WIDTH{1'b0}};
      wa3_q        <= 4'h0;
      pcsrc_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      pcsrc_q      <= pcsrc_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
    end
  end

  assign ALUOutM    = alu_out_q;
  assign WriteDataM = write_data_q;
  assign WA3M       = wa3_q;
  assign PCSrcM     = pcsrc_q;
  assign RegWriteM  = regwrite_q;
  assign MemtoRegM  = memtoreg_q;
  assign MemWriteM  = memwrite_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE, FlagWriteE, ForwardAE, ForwardBE;
  logic [3:0]  CondE, FlagsE, WA3E;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE;
  logic [3:0]  FlagsOut;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE, ALUOutM, WriteDataM;
  logic [3:0]  WA3M;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;

  int n_vec  = 0;
  int n_fail = 0;

  execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .FlagsE(FlagsE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .WA3E(WA3E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlagsOut(FlagsOut), .BranchTakenE(BranchTakenE),
    .BranchTargetE(BranchTargetE), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WA3M(WA3M), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {PCSrc, RegWrite, MemtoReg, MemWrite, Branch}
  // e_ctrlm = {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}
  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic        alusrc;
    logic [1:0]  aluctl, fw;
    logic [3:0]  cond, flags;
    logic [4:0]  ctrl;
    logic [3:0]  wa3;
    logic [3:0]  e_flags;
    logic        e_bt;
    logic [31:0] e_tgt, e_alu, e_wd;
    logic [3:0]  e_ctrlm;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ctrl(input logic [4:0] c);
    {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE} = c;
  endtask

  initial begin
    vecs[0]  = '{32'h7FFFFFFF, 32'h0000AAAA, 32'h00000001, 1'b1, 2'b00, 2'b11, 4'hE, 4'b0000, 5'b01000, 4'h3,
                 4'b1001, 1'b0, 32'h80000000, 32'h80000000, 32'h0000AAAA, 4'b0100};
    vecs[1]  = '{32'h00000005, 32'h00000005, 32'h00000099, 1'b0, 2'b01, 2'b11, 4'hE, 4'b0000, 5'b01100, 4'h4,
                 4'b0110, 1'b0, 32'h00000000, 32'h00000000, 32'h00000005, 4'b0110};
    vecs[2]  = '{32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 2'b00, 2'b00, 4'h0, 4'b0110, 5'b01000, 4'h5,
                 4'b0110, 1'b0, 32'h00000003, 32'h00000003, 32'h00000002, 4'b0100};
    vecs[3]  = '{32'h00000009, 32'h00000001, 32'h00000000, 1'b0, 2'b00, 2'b11, 4'h1, 4'b0100, 5'b00011, 4'h6,
                 4'b0100, 1'b0, 32'h0000000A, 32'h0000000A, 32'h00000001, 4'b0000};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 2'b00, 2'b11, 4'hE, 4'b0000, 5'b00000, 4'h7,
                 4'b0110, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
    vecs[5]  = '{32'h00000100, 32'h00000007, 32'h00000020, 1'b1, 2'b00, 2'b00, 4'hE, 4'b1010, 5'b10001, 4'h8,
                 4'b1010, 1'b1, 32'h00000120, 32'h00000120, 32'h00000007, 4'b1000};
    vecs[6]  = '{32'h0000F0F0, 32'h00000FF0, 32'h00000000, 1'b0, 2'b10, 2'b11, 4'hE, 4'b0011, 5'b01000, 4'h9,
                 4'b0000, 1'b0, 32'h000000F0, 32'h000000F0, 32'h00000FF0, 4'b0100};
    vecs[7]  = '{32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 2'b11, 2'b10, 4'hE, 4'b0011, 5'b00000, 4'hA,
                 4'b1011, 1'b0, 32'h80000001, 32'h80000001, 32'h00000000, 4'b0000};
    vecs[8]  = '{32'h00000003, 32'h00000000, 32'h00000005, 1'b1, 2'b01, 2'b11, 4'hE, 4'b0000, 5'b01000, 4'hB,
                 4'b1000, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000, 4'b0100};
    vecs[9]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 2'b00, 2'b01, 4'hB, 4'b1001, 5'b00110, 4'hC,
                 4'b1001, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0010};
    vecs[10] = '{32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 2'b01, 2'b01, 4'h8, 4'b0010, 5'b01000, 4'hD,
                 4'b0011, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 4'b0100};
    vecs[11] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2'b00, 2'b00, 4'hE, 4'b0101, 5'b00000, 4'h0,
                 4'b0101, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
    vecs[12] = '{32'h00000002, 32'h00000000, 32'h00000003, 1'b1, 2'b00, 2'b11, 4'hF, 4'b0000, 5'b11010, 4'hF,
                 4'b0000, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1101};

    reset = 1'b0;
    RD1E = 32'h0; RD2E = 32'h0; ExtImmE = 32'h0; ResultW = 32'h0;
    ALUSrcE = 1'b0; ALUControlE = 2'b00; FlagWriteE = 2'b00;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    CondE = 4'hE; FlagsE = 4'h0; WA3E = 4'h0;
    drive_ctrl(5'b00000);

    // Reset state
    #2;
    chk("reset_aluoutm", ALUOutM, 32'h0);
    chk("reset_wdm", WriteDataM, 32'h0);
    chk("reset_ctrlm", {28'h0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'h0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      RD1E = vecs[i].rd1; RD2E = vecs[i].rd2; ExtImmE = vecs[i].imm;
      ALUSrcE = vecs[i].alusrc; ALUControlE = vecs[i].aluctl;
      FlagWriteE = vecs[i].fw; CondE = vecs[i].cond; FlagsE = vecs[i].flags;
      WA3E = vecs[i].wa3; ForwardAE = 2'b00; ForwardBE = 2'b00;
      drive_ctrl(vecs[i].ctrl);
      #1;
      chk($sformatf("v%0d_flags", i), {28'h0, FlagsOut}, {28'h0, vecs[i].e_flags});
      chk($sformatf("v%0d_btaken", i), {31'h0, BranchTakenE}, {31'h0, vecs[i].e_bt});
      chk($sformatf("v%0d_btarget", i), BranchTargetE, vecs[i].e_tgt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_aluoutm", i), ALUOutM, vecs[i].e_alu);
      chk($sformatf("v%0d_wdm", i), WriteDataM, vecs[i].e_wd);
      chk($sformatf("v%0d_wa3m", i), {28'h0, WA3M}, {28'h0, vecs[i].wa3});
      chk($sformatf("v%0d_ctrlm", i), {28'h0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM},
          {28'h0, vecs[i].e_ctrlm});
    end

    // Forwarding: load 0x10 into ALUOutM, then forward it and ResultW
    RD1E = 32'h10; ExtImmE = 32'h0; ALUSrcE = 1'b1; ALUControlE = 2'b00;
    FlagWriteE = 2'b00; CondE = 4'hE; FlagsE = 4'h0; drive_ctrl(5'b00000);
    @(posedge clk); #1;
    chk("fwd_setup", ALUOutM, 32'h10);
    RD1E = 32'hDEAD; RD2E = 32'hBEEF; ResultW = 32'h3; ALUSrcE = 1'b0;
    ForwardAE = 2'b10; ForwardBE = 2'b01;
    #1;
    chk("fwd_target", BranchTargetE, 32'h13);
    @(posedge clk); #1;
    chk("fwd_aluoutm", ALUOutM, 32'h13);
    chk("fwd_wdm", WriteDataM, 32'h3);
    // Select 11 behaves as 00
    RD1E = 32'h1; RD2E = 32'h2; ForwardAE = 2'b11; ForwardBE = 2'b11;
    #1;
    chk("fwd11_target", BranchTargetE, 32'h3);
    @(posedge clk); #1;
    chk("fwd11_wdm", WriteDataM, 32'h2);
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Asynchronous reset mid-stream
    RD1E = 32'h55; ExtImmE = 32'h1; ALUSrcE = 1'b1; WA3E = 4'h9;
    CondE = 4'hE; drive_ctrl(5'b11110);
    @(posedge clk); #1;
    chk("pre_rst_regwritem", {31'h0, RegWriteM}, 32'h1);
    chk("pre_rst_aluoutm", ALUOutM, 32'h56);
    #2 reset = 1'b0;
    #1;
    chk("rst_aluoutm", ALUOutM, 32'h0);
    chk("rst_wa3m", {28'h0, WA3M}, 32'h0);
    chk("rst_ctrlm", {28'h0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'h0);
    chk("rst_comb_target", BranchTargetE, 32'h56);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_regwritem", {31'h0, RegWriteM}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
